// File: rtl/serial_ck_pkg.sv
// Shared definitions for the serial_ck scheduler.
//   state_e : scheduler FSM states, IDLE -> LOAD -> CHECK -> RUN -> GAP -> DONE
//   NCYC_W  : width of the ncyc configuration field
//   N_W     : width of n0/n1/n2 and of the cnt timebase
//   E_W     : width used to evaluate the transfer length before range check
//   clamp1  : maps 0 to 1; the generator treats zero counts as one
package serial_ck_pkg;

    localparam int NCYC_W = 8;
    localparam int N_W    = 32;
    localparam int E_W    = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [N_W-1:0] clamp1(input logic [N_W-1:0] x);
        return (x == '0) ? N_W'(1) : x;
    endfunction

endpackage

// File: rtl/serial_ck_sched_rr_arb.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index of the last served requester; search starts at ptr_i+1
//   win_o : one-hot winner (all zero when no request)
//   idx_o : encoded winner index
module rr_arb #(
    parameter int P_N  = 4,
    parameter int P_IW = 2
) (
    input  logic [P_N-1:0]  req_i,
    input  logic [P_IW-1:0] ptr_i,
    output logic [P_N-1:0]  win_o,
    output logic [P_IW-1:0] idx_o
);

    int   pos;
    logic found;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        // Walk the requesters in rotated order; the last served index comes last.
        for (int k = 1; k <= P_N; k++) begin
            pos = (int'(ptr_i) + k) % P_N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                win_o[pos] = 1'b1;
                idx_o      = pos[P_IW-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_ck_sched.sv
// Scheduler/configurator for one shared serial_ck clock generator.
//   clk, rst            : clock, synchronous active-high reset
//   req                 : per-requester request levels
//   cfg_y0/ncyc/n0/n1/n2: per-requester waveform configuration slices
//   gnt                 : one-hot grant held for the whole transfer
//   done, err           : completion pulse to the winner; err marks a rejected config
//   busy                : high whenever the scheduler is not idle
//   ck_rst, ck_*        : generator reset and registered configuration
//   ck_cnt              : timebase driven to the generator
module serial_ck_sched
    import serial_ck_pkg::*;
#(
    parameter int   P_N_REQ  = 4,
    parameter int   P_GAP    = 2,
    parameter logic P_Y_INIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_N_REQ-1:0]      req,
    input  logic [P_N_REQ-1:0]      cfg_y0,
    input  logic [8*P_N_REQ-1:0]    cfg_ncyc,
    input  logic [32*P_N_REQ-1:0]   cfg_n0,
    input  logic [32*P_N_REQ-1:0]   cfg_n1,
    input  logic [32*P_N_REQ-1:0]   cfg_n2,
    output logic [P_N_REQ-1:0]      gnt,
    output logic [P_N_REQ-1:0]      done,
    output logic                    err,
    output logic                    busy,
    output logic                    ck_rst,
    output logic                    ck_y0,
    output logic [NCYC_W-1:0]       ck_ncyc,
    output logic [N_W-1:0]          ck_n0,
    output logic [N_W-1:0]          ck_n1,
    output logic [N_W-1:0]          ck_n2,
    output logic [N_W-1:0]          ck_cnt
);

    localparam int IW = (P_N_REQ > 1) ? $clog2(P_N_REQ) : 1;

    state_e              state_q;
    logic [P_N_REQ-1:0]  gnt_q;
    logic [P_N_REQ-1:0]  done_q;
    logic                err_q;
    logic                ck_rst_q;
    logic                ck_y0_q;
    logic [NCYC_W-1:0]   ck_ncyc_q;
    logic [N_W-1:0]      ck_n0_q;
    logic [N_W-1:0]      ck_n1_q;
    logic [N_W-1:0]      ck_n2_q;
    logic [N_W-1:0]      cnt_q;
    logic [N_W-1:0]      e_q;
    logic [31:0]         gap_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       win_idx_q;

    logic [P_N_REQ-1:0]  arb_win;
    logic [IW-1:0]       arb_idx;
    logic [E_W-1:0]      e_d;

    rr_arb #(
        .P_N  (P_N_REQ),
        .P_IW (IW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (arb_win),
        .idx_o (arb_idx)
    );

    // Transfer length from the latched config; wide enough that the worst
    // case (ncyc=255, n1=n2=2^32-1) cannot overflow before the range check.
    always_comb begin
        e_d = E_W'(clamp1(ck_n0_q))
            + E_W'(clamp1(N_W'(ck_ncyc_q))) * (E_W'(clamp1(ck_n1_q)) + E_W'(clamp1(ck_n2_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            ck_rst_q  <= 1'b1;
            ck_y0_q   <= P_Y_INIT;
            ck_ncyc_q <= '0;
            ck_n0_q   <= '0;
            ck_n1_q   <= '0;
            ck_n2_q   <= '0;
            cnt_q     <= '0;
            e_q       <= '0;
            gap_q     <= '0;
            ptr_q     <= IW'(P_N_REQ - 1);
            win_idx_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q     <= arb_win;
                        win_idx_q <= arb_idx;
                        cnt_q     <= '0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ck_y0_q   <= cfg_y0[win_idx_q];
                    ck_ncyc_q <= cfg_ncyc[win_idx_q*NCYC_W +: NCYC_W];
                    ck_n0_q   <= cfg_n0[win_idx_q*N_W +: N_W];
                    ck_n1_q   <= cfg_n1[win_idx_q*N_W +: N_W];
                    ck_n2_q   <= cfg_n2[win_idx_q*N_W +: N_W];
                    state_q   <= ST_CHECK;
                end
                ST_CHECK: begin
                    // A length beyond the 32-bit timebase is refused; the
                    // generator stays in reset and the requester is told at once.
                    if (e_d > E_W'(32'hFFFF_FFFF)) begin
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        ptr_q   <= win_idx_q;
                        state_q <= ST_IDLE;
                    end else begin
                        e_q      <= e_d[N_W-1:0];
                        ck_rst_q <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == e_q) begin
                        ck_rst_q <= 1'b1;
                        gap_q    <= '0;
                        if (P_GAP == 0) begin
                            done_q  <= gnt_q;
                            gnt_q   <= '0;
                            ptr_q   <= win_idx_q;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 32'(P_GAP - 1)) begin
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        ptr_q   <= win_idx_q;
                        state_q <= ST_DONE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE);
    assign ck_rst  = ck_rst_q;
    assign ck_y0   = ck_y0_q;
    assign ck_ncyc = ck_ncyc_q;
    assign ck_n0   = ck_n0_q;
    assign ck_n1   = ck_n1_q;
    assign ck_n2   = ck_n2_q;
    assign ck_cnt  = cnt_q;

endmodule
